// File: rtl/ddr5_ctrl_top.sv
// ddr5_ctrl_top: closed-page DDR5-style controller with host FIFOs and 2-beat DQ bursts
// Ports: axi_clk/rst (async, active-high);
//   W_Valid/W_Address/W_Data/W_STRB feed the write FIFO (full2, empty2);
//   R_Valid_Address_x/R_Address feed the read-address FIFO (R_Ready_Address, full3, empty3);
//   R_Data/R_Error show the read-data FIFO head, popped by R_Ready (empty1);
//   empty4 is high while the sequencer is idle; CA/CS command bus; DQ bidirectional data.
module ddr5_ctrl_top #(
  parameter int FIFO_DEPTH = 4,
  parameter int T_RCD      = 2,
  parameter int CWL        = 2,
  parameter int CL         = 3,
  parameter int T_RP       = 2
) (
  input  logic        axi_clk,
  input  logic        rst,
  input  logic        W_Valid,
  input  logic [31:0] W_Address,
  input  logic [31:0] W_Data,
  input  logic [3:0]  W_STRB,
  output logic        full2,
  input  logic        R_Valid_Address_x,
  input  logic [31:0] R_Address,
  output logic        R_Ready_Address,
  output logic        full3,
  output logic [31:0] R_Data,
  output logic        R_Error,
  input  logic        R_Ready,
  output logic        empty1,
  output logic        empty2,
  output logic        empty3,
  output logic        empty4,
  output logic [13:0] CA,
  output logic        CS,
  inout  wire  [15:0] DQ
);
  typedef enum logic [2:0] {IDLE, ACT, RCD, CMD, DATA, PRE, RP} state_t;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR1 = 1;
  localparam logic [AW:0] CNT1 = 1;
  localparam logic [AW:0] CNTF = FIFO_DEPTH[AW:0];
  localparam logic [3:0] RD_LAST = 4'(CL + 2);
  state_t state, state_n;
  logic [3:0] cnt;
  logic is_rd, idle, hold, full1;
  logic [25:0] rc;
  logic [31:0] wdata, wmask;
  logic [15:0] beat0, beat1, dq_out;
  logic dq_oe, wf_pop, af_pop, df_pop, df_push, df_space, rd_sel, err_push, rd_push, wf_bad, af_bad, go;
  logic [63:0] f_din [3];
  logic [63:0] f_dout [3];
  logic [2:0] f_push, f_pop, f_empty, f_full;
  logic unused_ok;
  // FIFO 0: {addr, masked data} writes; 1: read addresses; 2: {err, data} read returns
  for (genvar i = 0; i < 3; i++) begin : g_fifo
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] n;
    logic pop_ok, push_ok;
    assign pop_ok = f_pop[i] && !f_empty[i];
    assign push_ok = f_push[i] && (!f_full[i] || pop_ok);
    assign f_empty[i] = n == '0;
    assign f_full[i] = n == CNTF;
    assign f_dout[i] = mem[rp];
    always_ff @(posedge axi_clk) if (push_ok) mem[wp] <= f_din[i];
    always_ff @(posedge axi_clk or posedge rst)
      if (rst) begin
        wp <= '0;
        rp <= '0;
        n <= '0;
      end else begin
        if (push_ok) wp <= wp + PTR1;
        if (pop_ok) rp <= rp + PTR1;
        n <= push_ok == pop_ok ? n : push_ok ? n + CNT1 : n - CNT1;
      end
  end
  assign wmask = {{8{W_STRB[3]}}, {8{W_STRB[2]}}, {8{W_STRB[1]}}, {8{W_STRB[0]}}};
  assign f_din[0] = {W_Address, W_Data & wmask};
  assign f_din[1] = {32'h0, R_Address};
  assign f_din[2] = err_push ? {31'h0, 1'b1, 32'h0} : {31'h0, 1'b0, beat1, beat0};
  assign f_push = {df_push, R_Valid_Address_x, W_Valid};
  assign f_pop = {df_pop, af_pop, wf_pop};
  assign {empty1, empty3, empty2} = f_empty;
  assign {full1, full3, full2} = f_full;
  assign R_Ready_Address = !full3;
  assign R_Data = empty1 ? 32'h0 : f_dout[2][31:0];
  assign R_Error = !empty1 && f_dout[2][32];
  assign empty4 = idle;
  assign unused_ok = ^{f_dout[0][33:32], f_dout[1][63:32], f_dout[1][1:0], f_dout[2][63:33]};
  assign idle = state == IDLE;
  assign wf_bad = f_dout[0][63:60] != 4'h0;
  assign af_bad = f_dout[1][31:28] != 4'h0;
  assign df_pop = R_Ready && !empty1;
  assign df_space = !full1 || df_pop;
  assign wf_pop = idle && !empty2;
  assign rd_sel = idle && empty2 && !empty3;
  // an out-of-range read completes in IDLE, so it waits there for read-data space
  assign err_push = rd_sel && af_bad && df_space;
  assign af_pop = rd_sel && (!af_bad || df_space);
  assign go = (wf_pop && !wf_bad) || (af_pop && !af_bad);
  assign rd_push = state == DATA && is_rd && cnt == RD_LAST && df_space;
  assign df_push = err_push || rd_push;
  assign hold = state == DATA && is_rd && cnt == RD_LAST;
  always_ff @(posedge axi_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 4'd0 : hold ? cnt : cnt + 4'd1;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = go ? ACT : IDLE;
      ACT: state_n = cnt == 4'd1 ? RCD : ACT;
      RCD: state_n = cnt == 4'(T_RCD - 1) ? CMD : RCD;
      CMD: state_n = cnt == 4'd1 ? DATA : CMD;
      DATA: state_n = (is_rd ? rd_push : cnt == 4'(CWL + 1)) ? PRE : DATA;
      PRE: state_n = cnt == 4'd1 ? RP : PRE;
      RP: state_n = cnt == 4'(T_RP - 1) ? IDLE : RP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk or posedge rst)
    if (rst) begin
      is_rd <= 1'b0;
      rc <= '0;
      wdata <= '0;
      beat0 <= '0;
      beat1 <= '0;
    end else begin
      if (wf_pop) begin
        is_rd <= 1'b0;
        rc <= f_dout[0][59:34];
        wdata <= f_dout[0][31:0];
      end else if (af_pop) begin
        is_rd <= 1'b1;
        rc <= f_dout[1][27:2];
      end
      if (state == DATA && is_rd && cnt == 4'(CL)) beat0 <= DQ;
      if (state == DATA && is_rd && cnt == 4'(CL + 1)) beat1 <= DQ;
    end
  // rc = {row[15:0], col[9:0]}
  always_comb begin
    CS = !(state == ACT || state == CMD || state == PRE);
    CA = state == ACT ? (cnt == 4'd0 ? {rc[21:10], 2'b00} : {10'h0, rc[25:22]})
       : state == CMD ? (cnt == 4'd0 ? (is_rd ? 14'h001D : 14'h000D) : {4'h0, rc[9:0]})
       : state == PRE && cnt == 4'd0 ? 14'h000B : 14'h0;
    dq_oe = state == DATA && !is_rd && (cnt == 4'(CWL) || cnt == 4'(CWL + 1));
    dq_out = cnt == 4'(CWL) ? wdata[15:0] : wdata[31:16];
  end
  assign DQ = dq_oe ? dq_out : 16'hzzzz;
endmodule

// File: tb/tb_ddr5_ctrl_top.sv
// tb_ddr5_ctrl_top: scoreboard bench for ddr5_ctrl_top with a DQ memory stub
module tb_ddr5_ctrl_top;
  localparam int CWL = 2, CL = 3;
  logic axi_clk = 1'b0, rst = 1'b1;
  logic W_Valid = 1'b0, R_Valid_Address_x = 1'b0, R_Ready = 1'b0;
  logic [31:0] W_Address = '0, W_Data = '0, R_Address = '0;
  logic [3:0] W_STRB = '0;
  logic full2, R_Ready_Address, full3, R_Error, empty1, empty2, empty3, empty4, CS;
  logic [31:0] R_Data;
  logic [13:0] CA;
  wire [15:0] DQ;
  logic [15:0] stub_dq = '0;
  logic stub_oe = 1'b0;
  int checks = 0, errors = 0;
  logic [13:0] exp_ca [$];
  logic [15:0] exp_dq [$];
  logic [32:0] exp_rd [$];
  assign DQ = stub_oe ? stub_dq : 16'hzzzz;
  always #5 axi_clk = ~axi_clk;
  ddr5_ctrl_top dut (
    .axi_clk(axi_clk), .rst(rst), .W_Valid(W_Valid), .W_Address(W_Address), .W_Data(W_Data),
    .W_STRB(W_STRB), .full2(full2), .R_Valid_Address_x(R_Valid_Address_x), .R_Address(R_Address),
    .R_Ready_Address(R_Ready_Address), .full3(full3), .R_Data(R_Data), .R_Error(R_Error),
    .R_Ready(R_Ready), .empty1(empty1), .empty2(empty2), .empty3(empty3), .empty4(empty4),
    .CA(CA), .CS(CS), .DQ(DQ)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  // monitor: every command cycle, DUT-driven DQ beat and read-data pop is matched against the queues
  initial forever begin
    @(negedge axi_clk);
    #2;
    if (!rst) begin
      if (!CS) begin
        if (exp_ca.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ca_unexpected got %h expected none", CA);
        end else chk("ca", 64'(CA), 64'(exp_ca.pop_front()));
      end
      if (!stub_oe && DQ !== 16'hzzzz) begin
        if (exp_dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dq_unexpected got %h expected none", DQ);
        end else chk("dq", 64'(DQ), 64'(exp_dq.pop_front()));
      end
      if (R_Ready && !empty1) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected got %h expected none", {R_Error, R_Data});
        end else chk("rd", 64'({R_Error, R_Data}), 64'(exp_rd.pop_front()));
      end
    end
  end
  // DRAM stub: decodes ACT/WR/RD, stores write beats by {row,col}, returns them CL after RD
  initial begin
    int cyc, wr_at, rd_at;
    logic ph;
    logic [13:0] c1;
    logic [15:0] row, wlo;
    logic [25:0] key;
    logic [31:0] smem [logic [25:0]];
    cyc = 0;
    wr_at = -100;
    rd_at = -100;
    ph = 1'b0;
    c1 = '0;
    row = '0;
    wlo = '0;
    key = '0;
    forever begin
      @(negedge axi_clk);
      #1;
      cyc++;
      if (rst) begin
        ph = 1'b0;
        wr_at = -100;
        rd_at = -100;
        stub_oe = 1'b0;
      end else begin
        if (!CS) begin
          if (!ph) c1 = CA;
          else if (c1[1:0] == 2'b00) row = {CA[3:0], c1[13:2]};
          else if (c1 == 14'h000D) begin
            key = {row, CA[9:0]};
            wr_at = cyc + CWL + 1;
          end else if (c1 == 14'h001D) begin
            key = {row, CA[9:0]};
            rd_at = cyc + CL + 1;
          end
          ph = !ph;
        end
        if (cyc == wr_at) wlo = DQ;
        if (cyc == wr_at + 1) smem[key] = {DQ, wlo};
        stub_oe = (cyc == rd_at || cyc == rd_at + 1) && smem.exists(key);
        if (stub_oe) stub_dq = cyc == rd_at ? smem[key][15:0] : smem[key][31:16];
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic exp_cmds(input logic [13:0] a1, a2, c1, c2);
    exp_ca.push_back(a1);
    exp_ca.push_back(a2);
    exp_ca.push_back(c1);
    exp_ca.push_back(c2);
    exp_ca.push_back(14'h000B);
    exp_ca.push_back(14'h0000);
  endtask
  task automatic wr(input logic [31:0] a, d, input logic [3:0] s);
    @(negedge axi_clk);
    W_Valid = 1'b1;
    W_Address = a;
    W_Data = d;
    W_STRB = s;
    @(negedge axi_clk);
    W_Valid = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    @(negedge axi_clk);
    R_Valid_Address_x = 1'b1;
    R_Address = a;
    @(negedge axi_clk);
    R_Valid_Address_x = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge axi_clk);
      #2;
      k++;
    end while (!(empty2 && empty3 && empty4) && k < 100);
    chk(name, 64'(empty2 && empty3 && empty4), 64'd1);
  endtask
  initial begin
    int k;
    #7;
    chk("rst_cs", 64'(CS), 64'd1);
    chk("rst_ca", 64'(CA), 64'd0);
    chk("rst_dq_z", 64'(DQ === 16'hzzzz), 64'd1);
    chk("rst_empty", 64'({empty1, empty2, empty3, empty4}), 64'hf);
    chk("rst_full", 64'({full2, full3}), 64'd0);
    chk("rst_rra", 64'(R_Ready_Address), 64'd1);
    chk("rst_rdata", 64'({R_Error, R_Data}), 64'd0);
    @(negedge axi_clk);
    rst = 1'b0;
    // 1: write 0x14253679 @0x4567
    exp_cmds(14'h010, 14'h000, 14'h00D, 14'h159);
    exp_dq.push_back(16'h3679);
    exp_dq.push_back(16'h1425);
    wr(32'h4567, 32'h1425_3679, 4'hF);
    wait_idle("t1_idle");
    chk("t1_empty2", 64'(empty2), 64'd1);
    // 2: write 0x5148AECF @0x4599
    exp_cmds(14'h010, 14'h000, 14'h00D, 14'h166);
    exp_dq.push_back(16'hAECF);
    exp_dq.push_back(16'h5148);
    wr(32'h4599, 32'h5148_AECF, 4'hF);
    wait_idle("t2_idle");
    chk("t2_empty4", 64'(empty4), 64'd1);
    // 3: read @0x4567 with R_Ready low, head must hold
    exp_cmds(14'h010, 14'h000, 14'h01D, 14'h159);
    exp_rd.push_back({1'b0, 32'h1425_3679});
    rd(32'h4567);
    wait_idle("t3_idle");
    chk("t3_empty1", 64'(empty1), 64'd0);
    chk("t3_head", 64'({R_Error, R_Data}), 64'({1'b0, 32'h1425_3679}));
    repeat (3) @(negedge axi_clk);
    #2;
    chk("t3_hold", 64'({empty1, R_Error, R_Data}), 64'({1'b0, 1'b0, 32'h1425_3679}));
    // 4: read @0x4599, then drain both entries
    exp_cmds(14'h010, 14'h000, 14'h01D, 14'h166);
    exp_rd.push_back({1'b0, 32'h5148_AECF});
    rd(32'h4599);
    wait_idle("t4_idle");
    chk("t4_head", 64'(R_Data), 64'h1425_3679);
    @(negedge axi_clk);
    R_Ready = 1'b1;
    k = 0;
    while (!empty1 && k < 10) begin
      @(negedge axi_clk);
      #3;
      k++;
    end
    R_Ready = 1'b0;
    chk("t4_empty1", 64'(empty1), 64'd1);
    // 5: out-of-range read returns an error entry without any command
    rd(32'h1000_0000);
    wait_idle("t5_idle");
    chk("t5_empty1", 64'(empty1), 64'd0);
    chk("t5_head", 64'({R_Error, R_Data}), 64'({1'b1, 32'h0}));
    exp_rd.push_back({1'b1, 32'h0});
    @(negedge axi_clk);
    R_Ready = 1'b1;
    @(negedge axi_clk);
    R_Ready = 1'b0;
    #2;
    chk("t5_drained", 64'(empty1), 64'd1);
    // 6: one write starts, five more back-to-back fill the FIFO, then reset mid-burst
    exp_ca.push_back(14'h020);
    exp_ca.push_back(14'h000);
    exp_ca.push_back(14'h00D);
    exp_ca.push_back(14'h008);
    exp_dq.push_back(16'h00EF);
    @(negedge axi_clk);
    W_Valid = 1'b1;
    W_Address = 32'h8020;
    W_Data = 32'hDEAD_BEEF;
    W_STRB = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_clk);
      W_Address = 32'h100 + 32'(4 * i);
      W_Data = 32'(i);
      W_STRB = 4'hF;
    end
    @(negedge axi_clk);
    W_Valid = 1'b0;
    #2;
    chk("t6_full2", 64'(full2), 64'd1);
    chk("t6_busy", 64'({empty2, empty4}), 64'd0);
    k = 0;
    while (DQ === 16'hzzzz && k < 40) begin
      @(negedge axi_clk);
      #2;
      k++;
    end
    chk("t6_dq_seen", 64'(DQ !== 16'hzzzz), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_cs", 64'(CS), 64'd1);
    chk("t6_rst_dq_z", 64'(DQ === 16'hzzzz), 64'd1);
    chk("t6_rst_ca", 64'(CA), 64'd0);
    chk("t6_rst_flags", 64'({empty1, empty2, empty3, empty4, full2, full3, R_Ready_Address}), 64'b1111001);
    @(negedge axi_clk);
    rst = 1'b0;
    repeat (3) @(negedge axi_clk);
    #2;
    chk("t6_quiet", 64'({CS, empty4}), 64'b11);
    chk("exp_ca_left", 64'(exp_ca.size()), 64'd0);
    chk("exp_dq_left", 64'(exp_dq.size()), 64'd0);
    chk("exp_rd_left", 64'(exp_rd.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
